// File: rtl/waveform_pwm_dac.sv
// -----------------------------------------------------------------------------
// waveform_pwm_dac
//
// Single-bit PWM DAC fed by the waveform generator. Each WIDTH-bit sample is
// taken through a valid/ready handshake into a shadow register. The shadow
// value becomes the PWM duty only at a period boundary, so no carrier period
// ever mixes two duty values. A prescaler sets the carrier tick rate.
//
// Handshake: a sample transfers on the rising clk edge where sample_valid and
// sample_ready are both high. sample_ready is high exactly when the shadow
// register is empty. The upstream stage holds sample stable while valid is
// high and ready is low. The handshake works whether or not en is high.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-low reset
//   en            in   run enable; low holds the carrier idle (cnt=0, pwm=0)
//   sample        in   WIDTH-bit duty value
//   sample_valid  in   sample is valid this cycle
//   sample_ready  out  shadow register empty
//   pwm_out       out  registered PWM output
//   period_done   out  one-clk pulse after each period boundary tick
//   dbg_state_o   out  FSM state (0 = IDLE, 1 = RUN)
//   dbg_cnt_o     out  PWM counter value
//
// Build option: define PWM_CENTER_ALIGNED_EN for a centre-aligned (up/down)
// carrier. The period then doubles. The boundary is the tick at cnt=0 while
// counting down. Without the macro the carrier is an edge-aligned sawtooth.
// -----------------------------------------------------------------------------
module waveform_pwm_dac #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             pwm_out,
  output logic             period_done,
  output logic             dbg_state_o,
  output logic [WIDTH-1:0] dbg_cnt_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int               PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             full_q, full_d;
  logic             pwm_q, pwm_d;
  logic             pd_q, pd_d;
`ifdef PWM_CENTER_ALIGNED_EN
  logic             down_q, down_d;
`endif

  logic run;
  logic tick;
  logic boundary;
  logic accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      cnt_q    <= '0;
      duty_q   <= '0;
      shadow_q <= '0;
      full_q   <= 1'b0;
      pwm_q    <= 1'b0;
      pd_q     <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
      down_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      shadow_q <= shadow_d;
      full_q   <= full_d;
      pwm_q    <= pwm_d;
      pd_q     <= pd_d;
`ifdef PWM_CENTER_ALIGNED_EN
      down_q   <= down_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    duty_d   = duty_q;
    shadow_d = shadow_q;
    full_d   = full_q;
    pwm_d    = 1'b0;
    pd_d     = 1'b0;
    boundary = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
    down_d   = down_q;
`endif

    case (state_q)
      IDLE:    if (en)  state_d = RUN;
      RUN:     if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Counting is gated by the next state, so the first tick lands PRESCALE
    // cycles after en rises and leaving RUN clears the carrier on that edge.
    run    = (state_d == RUN);
    tick   = run && (presc_q == PRESC_MAX);
    accept = sample_valid && !full_q;

    if (run) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end else begin
      presc_d = '0;
      cnt_d   = '0;
`ifdef PWM_CENTER_ALIGNED_EN
      down_d  = 1'b0;
`endif
    end

    if (tick) begin
`ifdef PWM_CENTER_ALIGNED_EN
      // Each end value is held for two ticks (turnaround), which gives a
      // 2^(WIDTH+1)-tick period that is symmetric about its centre.
      if (!down_q) begin
        if (cnt_q == CNT_MAX) down_d = 1'b1;
        else                  cnt_d  = cnt_q + 1'b1;
      end else begin
        if (cnt_q == '0) begin
          down_d   = 1'b0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`else
      cnt_d    = cnt_q + 1'b1;
      boundary = (cnt_q == CNT_MAX);
`endif
    end

    if (boundary) begin
      pd_d = 1'b1;
      if (full_q) begin
        duty_d = shadow_q;
        full_d = 1'b0;
      end
    end

    // Accept needs full_q=0 and commit needs full_q=1, so both can never
    // happen on the same edge. A sample accepted on a boundary edge waits in
    // the shadow register for the next boundary.
    if (accept) begin
      shadow_d = sample;
      full_d   = 1'b1;
    end

    pwm_d = run && (cnt_q < duty_q);
  end

  assign sample_ready = !full_q;
  assign pwm_out      = pwm_q;
  assign period_done  = pd_q;
  assign dbg_state_o  = state_q;
  assign dbg_cnt_o    = cnt_q;

endmodule

// File: tb/tb_waveform_pwm_dac.sv
// -----------------------------------------------------------------------------
// tb_waveform_pwm_dac
//
// Directed bench for waveform_pwm_dac. It uses two instances that share clk
// and rst. dut1 uses PRESCALE=1 and dut4 uses PRESCALE=4. Every expected value
// below is hand-computed from the carrier definition: a period has PER ticks,
// and pwm is high for one tick per counter value below duty (twice per value
// in centre-aligned mode).
// -----------------------------------------------------------------------------
module tb_waveform_pwm_dac;

`ifdef PWM_CENTER_ALIGNED_EN
  localparam int M = 2;
`else
  localparam int M = 1;
`endif
  localparam int PER = 256 * M;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- dut1 (PRESCALE=1) ----------------
  logic       en, sample_valid;
  logic [7:0] sample;
  logic       rdy, pwm, pd, st;
  logic [7:0] cnt;

  waveform_pwm_dac #(.WIDTH(8), .PRESCALE(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (rdy),
    .pwm_out      (pwm),
    .period_done  (pd),
    .dbg_state_o  (st),
    .dbg_cnt_o    (cnt)
  );

  // ---------------- dut4 (PRESCALE=4) ----------------
  logic       en4, valid4;
  logic [7:0] sample4;
  logic       rdy4, pwm4, pd4, st4;
  logic [7:0] cnt4;

  waveform_pwm_dac #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk          (clk),
    .rst          (rst),
    .en           (en4),
    .sample       (sample4),
    .sample_valid (valid4),
    .sample_ready (rdy4),
    .pwm_out      (pwm4),
    .period_done  (pd4),
    .dbg_state_o  (st4),
    .dbg_cnt_o    (cnt4)
  );

  // Monitor mux: the shared tasks observe whichever instance is selected.
  logic       use4;
  logic       mon_pwm, mon_pd;
  logic [7:0] mon_cnt;
  assign mon_pwm = use4 ? pwm4 : pwm;
  assign mon_pd  = use4 ? pd4  : pd;
  assign mon_cnt = use4 ? cnt4 : cnt;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Outputs are sampled 1 ns after the rising edge and inputs change there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until period_done. It returns the step count and the number of
  // pwm-high samples. When started on a period_done sample, it measures
  // exactly one full period.
  task automatic run_to_pd(input string tag, output int len, output int hi);
    len = 0;
    hi  = 0;
    do begin
      step();
      len++;
      hi += int'(mon_pwm);
    end while (!mon_pd && len < 5000);
    if (!mon_pd) chk({tag, "_pd_timeout"}, mon_pd, 1);
  endtask

  task automatic wait_cnt(input string tag, input logic [7:0] v);
    int guard;
    guard = 0;
    while (mon_cnt != v && guard < 5000) begin
      step();
      guard++;
    end
    chk(tag, mon_cnt, v);
  endtask

  // ---------------- stimulus ----------------
  int len, hi;

  initial begin
    rst = 1'b0; en = 1'b0; sample = '0; sample_valid = 1'b0;
    en4 = 1'b0; sample4 = '0; valid4 = 1'b0; use4 = 1'b0;

    // Reset state
    #3;
    chk("rst_ready", rdy, 1);
    chk("rst_pwm",   pwm, 0);
    chk("rst_pd",    pd,  0);
    chk("rst_cnt",   cnt, 0);
    chk("rst_state", st,  0);
    chk("rst_ready4", rdy4, 1);
    @(negedge clk);
    rst = 1'b1;
    step();
    step();

    // Reset duty 0, then 0x40 sent at cycle 5 after en
    en = 1'b1;
    len = 0; hi = 0;
    do begin
      step();
      len++;
      hi += int'(pwm);
      if (len == 4) begin sample = 8'h40; sample_valid = 1'b1; end
      if (len == 5) begin chk("t1_accept_ready_low", rdy, 0); sample_valid = 1'b0; end
    end while (!pd && len < 5000);
    chk("t1_first_pd_cycle", len, PER);
    chk("t1_first_hi",       hi,  0);
    chk("t1_ready_after_commit", rdy, 1);
    run_to_pd("t1", len, hi);
    chk("t1_period_len", len, PER);
    chk("t1_hi_0x40",    hi,  64 * M);

    // Back-pressure: 0x10 accepted, 0x20 stalls until the next boundary
    sample = 8'h10; sample_valid = 1'b1;
    step();
    chk("bp_first_taken", rdy, 0);
    sample = 8'h20;
    run_to_pd("bp_a", len, hi);
    chk("bp_len_to_boundary", len, PER - 1);
    chk("bp_ready_at_boundary", rdy, 1);
    run_to_pd("bp_b", len, hi);
    chk("bp_hi_0x10", hi, 16 * M);
    chk("bp_ready_at_boundary2", rdy, 1);
    sample_valid = 1'b0;
    run_to_pd("bp_c", len, hi);
    chk("bp_hi_0x20", hi, 32 * M);

`ifndef PWM_CENTER_ALIGNED_EN
    // Accept on the boundary edge with shadow empty: duty is unchanged for
    // one more period and the sample commits at the following boundary.
    wait_cnt("sim_reach_255", 8'hFF);
    sample = 8'hFF; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk("sim_pd",    pd,  1);
    chk("sim_ready", rdy, 0);
    run_to_pd("sim_a", len, hi);
    chk("sim_hi_old_duty", hi, 32);
`else
    sample = 8'hFF; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    run_to_pd("sim_a", len, hi);
`endif
    run_to_pd("ff", len, hi);
    chk("ff_hi", hi, 255 * M);
    chk("ff_len", len, PER);

    // Enable drop at cnt=100 clears the carrier and keeps the duty
    wait_cnt("en_reach_100", 8'd100);
    chk("en_pwm_before_drop", pwm, 1);
    en = 1'b0;
    step();
    chk("en_drop_pwm",   pwm, 0);
    chk("en_drop_cnt",   cnt, 0);
    chk("en_drop_state", st,  0);
    step();
    step();
    chk("en_idle_cnt", cnt, 0);
    en = 1'b1;
    run_to_pd("en_re", len, hi);
    chk("en_restart_len",  len, PER);
    chk("en_retained_hi",  hi,  255 * M);

    // Duty 0x00
    sample = 8'h00; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    run_to_pd("z_a", len, hi);
    run_to_pd("z_b", len, hi);
    chk("zero_hi",  hi,  0);
    chk("zero_len", len, PER);
    en = 1'b0;

    // Prescale 4 on dut4; handshake works while idle
    use4 = 1'b1;
    sample4 = 8'h80; valid4 = 1'b1;
    step();
    valid4 = 1'b0;
    chk("p4_accept_idle", rdy4, 0);
    step();
    chk("p4_idle_cnt", cnt4, 0);
    en4 = 1'b1;
    run_to_pd("p4_a", len, hi);
    chk("p4_first_pd", len, 1024 * M);
    chk("p4_first_hi", hi,  0);
    run_to_pd("p4_b", len, hi);
    chk("p4_period_len", len, 1024 * M);
    chk("p4_hi_0x80",    hi,  512 * M);

    // Asynchronous reset between clock edges
    sample4 = 8'h33; valid4 = 1'b1;
    step();
    valid4 = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("ar_pwm_before", pwm4, 1);
    chk("ar_ready_before", rdy4, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("ar_pwm",   pwm4, 0);
    chk("ar_pd",    pd4,  0);
    chk("ar_ready", rdy4, 1);
    chk("ar_cnt",   cnt4, 0);
    chk("ar_state", st4,  0);
    @(negedge clk);
    rst = 1'b1;
    run_to_pd("ar_resume", len, hi);
    chk("ar_resume_len", len, 1024 * M);
    chk("ar_resume_hi",  hi,  0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
